// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU and an external requester (loader or debug port).
// Each access is latched in IDLE and stepped through ACCESS, CAPTURE and DONE. Writes finish
// in ACCESS. Reads hold mem_rd through ACCESS and CAPTURE, load the owner's rdata register at
// the end of CAPTURE, and ack in DONE. The CPU wins ties unless the wait counter has saturated.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   cpu_req/we/byt/addr/wdata CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack        registered CPU read data, one-cycle completion pulse
//   cpu_stall                 cpu_req & ~cpu_ack (combinational, forced low in reset)
//   ext_*                     external requester, same meaning as the CPU ports
//   mem_addr/wdata/rd/wr/byt  registered memory strobes and payload
//   mem_rdata                 memory read data, sampled during CAPTURE
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned EXT_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byt,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_byt,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_byt,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LAT_W  = 3;
  localparam int unsigned WAIT_W = 4;
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(EXT_MAX_WAIT);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                byt_q, byt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ext_ack_q, ext_ack_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                mem_byt_q, mem_byt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Working signals for the next-state block.
  logic                grant_ext;
  logic                mem_act;
  logic                ack_now;
  logic [DATA_W-1:0]   cap_data;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      byt_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      wait_q      <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_byt_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      byt_q       <= byt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_byt_q   <= mem_byt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    byt_d       = byt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    grant_ext   = 1'b0;
    cap_data    = byt_q ? DATA_W'(mem_rdata[7:0]) : mem_rdata;

    unique case (state_q)
      IDLE: begin
        grant_ext = ext_req && (!cpu_req || (wait_q == WAIT_MAX));
        if (grant_ext) begin
          owner_d = OWN_EXT;
          we_d    = ext_we;
          byt_d   = ext_byt;
          addr_d  = ext_addr;
          wdata_d = ext_wdata;
          lat_d   = LAT_LOAD;
          wait_d  = '0;
          state_d = ACCESS;
        end else if (cpu_req) begin
          owner_d = OWN_CPU;
          we_d    = cpu_we;
          byt_d   = cpu_byt;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          lat_d   = LAT_LOAD;
          state_d = ACCESS;
          // Count CPU grants that overtook a pending ext request, saturating.
          if (ext_req && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        if (!ext_req) begin
          wait_d = '0;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (lat_q <= LAT_W'(1)) begin
          state_d = CAPTURE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      CAPTURE: begin
        if (owner_q == OWN_EXT) begin
          ext_rdata_d = cap_data;
        end else begin
          cpu_rdata_d = cap_data;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory is driven only while a transaction occupies ACCESS or CAPTURE.
    mem_act     = (state_d == ACCESS) || (state_d == CAPTURE);
    mem_wr_d    = (state_d == ACCESS) && we_d;
    mem_rd_d    = mem_act && !we_d;
    mem_byt_d   = mem_act && byt_d;
    mem_addr_d  = mem_act ? addr_d : '0;
    mem_wdata_d = mem_act ? wdata_d : '0;

    // Writes ack in their single ACCESS cycle, reads in DONE.
    ack_now   = ((state_d == ACCESS) && we_d && (state_q == IDLE)) || (state_d == DONE);
    cpu_ack_d = ack_now && (owner_d == OWN_CPU);
    ext_ack_d = ack_now && (owner_d == OWN_EXT);
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_byt   = mem_byt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Stall follows the raw request so the CPU freezes in the very cycle it asks.
  assign cpu_stall = rst & cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions on an RD_LAT=1
// instance, plus hand-written sequences for arbitration fairness, reset mid-read and an
// RD_LAT=3 instance with a waiting CPU request.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_byt;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        ext_req, ext_we, ext_byt;
  logic [15:0] ext_addr, ext_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] d1_cpu_rdata, d1_ext_rdata, d1_mem_addr, d1_mem_wdata;
  logic        d1_cpu_ack, d1_cpu_stall, d1_ext_ack, d1_mem_rd, d1_mem_wr, d1_mem_byt;
  logic [15:0] d3_cpu_rdata, d3_ext_rdata, d3_mem_addr, d3_mem_wdata;
  logic        d3_cpu_ack, d3_cpu_stall, d3_ext_ack, d3_mem_rd, d3_mem_wr, d3_mem_byt;

  logic        sel3 = 1'b0;
  logic [15:0] s_cpu_rdata, s_ext_rdata, s_mem_addr, s_mem_wdata;
  logic        s_cpu_ack, s_cpu_stall, s_ext_ack, s_mem_rd, s_mem_wr, s_mem_byt;

  assign s_cpu_rdata = sel3 ? d3_cpu_rdata : d1_cpu_rdata;
  assign s_ext_rdata = sel3 ? d3_ext_rdata : d1_ext_rdata;
  assign s_mem_addr  = sel3 ? d3_mem_addr  : d1_mem_addr;
  assign s_mem_wdata = sel3 ? d3_mem_wdata : d1_mem_wdata;
  assign s_cpu_ack   = sel3 ? d3_cpu_ack   : d1_cpu_ack;
  assign s_cpu_stall = sel3 ? d3_cpu_stall : d1_cpu_stall;
  assign s_ext_ack   = sel3 ? d3_ext_ack   : d1_ext_ack;
  assign s_mem_rd    = sel3 ? d3_mem_rd    : d1_mem_rd;
  assign s_mem_wr    = sel3 ? d3_mem_wr    : d1_mem_wr;
  assign s_mem_byt   = sel3 ? d3_mem_byt   : d1_mem_byt;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .EXT_MAX_WAIT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byt(cpu_byt), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(d1_cpu_rdata), .cpu_ack(d1_cpu_ack),
    .cpu_stall(d1_cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_byt(ext_byt), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(d1_ext_rdata), .ext_ack(d1_ext_ack),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_rd(d1_mem_rd),
    .mem_wr(d1_mem_wr), .mem_byt(d1_mem_byt), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .EXT_MAX_WAIT(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byt(cpu_byt), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(d3_cpu_rdata), .cpu_ack(d3_cpu_ack),
    .cpu_stall(d3_cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_byt(ext_byt), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(d3_ext_rdata), .ext_ack(d3_ext_ack),
    .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata), .mem_rd(d3_mem_rd),
    .mem_wr(d3_mem_wr), .mem_byt(d3_mem_byt), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m_cpu_rd = 16'h0000;
  logic [15:0] m_ext_rd = 16'h0000;

  typedef struct {
    logic        ext;
    logic        we;
    logic        byt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction, started with the DUT in IDLE, checked cycle by cycle up to its ack.
  task automatic run_txn(input vec_t v, input int lat, input string tag);
    int   ack_k;
    logic exp_rd, exp_wr;
    ack_k = v.we ? 1 : lat + 2;
    if (v.ext) begin
      ext_req = 1'b1; ext_we = v.we; ext_byt = v.byt; ext_addr = v.addr; ext_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_byt = v.byt; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= ack_k; k++) begin
      @(posedge clk); #1;
      exp_rd = !v.we && (k <= lat + 1);
      exp_wr = v.we && (k == 1);
      chk($sformatf("%s k%0d mem_rd", tag, k), 32'(s_mem_rd), 32'(exp_rd));
      chk($sformatf("%s k%0d mem_wr", tag, k), 32'(s_mem_wr), 32'(exp_wr));
      if (exp_rd || exp_wr) begin
        chk($sformatf("%s k%0d mem_addr", tag, k), 32'(s_mem_addr), 32'(v.addr));
        chk($sformatf("%s k%0d mem_byt", tag, k), 32'(s_mem_byt), 32'(v.byt));
      end
      if (exp_wr) chk($sformatf("%s mem_wdata", tag), 32'(s_mem_wdata), 32'(v.wdata));
      chk($sformatf("%s k%0d cpu_ack", tag, k), 32'(s_cpu_ack), 32'((k == ack_k) && !v.ext));
      chk($sformatf("%s k%0d ext_ack", tag, k), 32'(s_ext_ack), 32'((k == ack_k) && v.ext));
      if (!v.ext) chk($sformatf("%s k%0d cpu_stall", tag, k), 32'(s_cpu_stall), 32'(k != ack_k));
      mem_rdata = (!v.we && (k == lat + 1)) ? v.mrd : 16'hDEAD;
    end
    if (!v.we) begin
      if (v.ext) m_ext_rd = v.exp_rd;
      else       m_cpu_rd = v.exp_rd;
    end
    chk($sformatf("%s cpu_rdata", tag), 32'(s_cpu_rdata), 32'(m_cpu_rd));
    chk($sformatf("%s ext_rdata", tag), 32'(s_ext_rdata), 32'(m_ext_rd));
    cpu_req = 1'b0;
    ext_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_both();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_cpu_rd = 16'h0000;
    m_ext_rd = 16'h0000;
    @(posedge clk); #1;
  endtask

  initial begin
    int   got[$];
    int   overlap;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0101, 16'h0000, 16'h12AB, 16'h00AB};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0200, 16'h5A5A, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h1234, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0301, 16'h0000, 16'hFF80, 16'h0080};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0400, 16'hA5A5, 16'h0000, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h8001, 16'h8001};

    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byt = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_byt = 1'b0; ext_addr = '0; ext_wdata = '0;
    mem_rdata = 16'hDEAD;

    // Reset state, with cpu_req held to show stall is suppressed.
    repeat (3) @(posedge clk);
    #1;
    chk("rst cpu_rdata", 32'(d1_cpu_rdata), 32'h0);
    chk("rst ext_rdata", 32'(d1_ext_rdata), 32'h0);
    chk("rst cpu_ack", 32'(d1_cpu_ack), 32'h0);
    chk("rst ext_ack", 32'(d1_ext_ack), 32'h0);
    chk("rst mem_rd", 32'(d1_mem_rd), 32'h0);
    chk("rst mem_wr", 32'(d1_mem_wr), 32'h0);
    chk("rst mem_addr", 32'(d1_mem_addr), 32'h0);
    chk("rst cpu_stall", 32'(d1_cpu_stall), 32'h0);
    cpu_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Table of single transactions on the RD_LAT=1 instance.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], 1, $sformatf("vec%0d", i));
    end

    // Both requesters held: four CPU grants, then one forced ext grant, repeating.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byt = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h1111;
    ext_req = 1'b1; ext_we = 1'b1; ext_byt = 1'b0; ext_addr = 16'h0020; ext_wdata = 16'h2222;
    overlap = 0;
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      @(posedge clk); #1;
      if (d1_cpu_ack && d1_ext_ack) overlap++;
      if (d1_cpu_ack) got.push_back(0);
      else if (d1_ext_ack) got.push_back(1);
    end
    cpu_req = 1'b0;
    ext_req = 1'b0;
    chk("fair ack count", 32'(got.size()), 32'd10);
    chk("fair ack overlap", 32'(overlap), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i < got.size()) chk($sformatf("fair grant%0d", i), 32'(got[i]), 32'((i % 5) == 4));
    end
    chk("fair cpu_rdata held", 32'(d1_cpu_rdata), 32'(m_cpu_rd));
    chk("fair ext_rdata held", 32'(d1_ext_rdata), 32'(m_ext_rd));
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted while a CPU read sits in CAPTURE.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byt = 1'b0; cpu_addr = 16'h0500;
    @(posedge clk); #1;
    mem_rdata = 16'h7777;
    @(posedge clk); #1;
    chk("rstmid mem_rd before", 32'(d1_mem_rd), 32'h1);
    rst = 1'b0;
    #1;
    chk("rstmid mem_rd", 32'(d1_mem_rd), 32'h0);
    chk("rstmid cpu_ack", 32'(d1_cpu_ack), 32'h0);
    chk("rstmid cpu_rdata", 32'(d1_cpu_rdata), 32'h0);
    chk("rstmid ext_rdata", 32'(d1_ext_rdata), 32'h0);
    chk("rstmid mem_addr", 32'(d1_mem_addr), 32'h0);
    m_cpu_rd = 16'h0000;
    m_ext_rd = 16'h0000;
    cpu_req = 1'b0;
    mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    chk("rstmid no ack", 32'(d1_cpu_ack), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hC0DE, 16'hC0DE};
    run_txn(v, 1, "after_rst");

    // RD_LAT=3 instance: ext read granted first, CPU read waits behind it.
    reset_both();
    sel3 = 1'b1;
    ext_req = 1'b1; ext_we = 1'b0; ext_byt = 1'b0; ext_addr = 16'h0600;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat3 k%0d mem_rd", k), 32'(s_mem_rd),
          32'(((k >= 1) && (k <= 4)) || ((k >= 7) && (k <= 10))));
      if ((k >= 1) && (k <= 4)) chk($sformatf("lat3 k%0d addr", k), 32'(s_mem_addr), 32'h0600);
      if ((k >= 7) && (k <= 10)) chk($sformatf("lat3 k%0d addr", k), 32'(s_mem_addr), 32'h0700);
      chk($sformatf("lat3 k%0d ext_ack", k), 32'(s_ext_ack), 32'(k == 5));
      chk($sformatf("lat3 k%0d cpu_ack", k), 32'(s_cpu_ack), 32'(k == 11));
      chk($sformatf("lat3 k%0d cpu_stall", k), 32'(s_cpu_stall), 32'((k >= 2) && (k <= 10)));
      mem_rdata = (k == 4) ? 16'h3C3C : ((k == 10) ? 16'h4D4D : 16'hDEAD);
      if (k == 1) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byt = 1'b0; cpu_addr = 16'h0700;
      end
      if (k == 5) ext_req = 1'b0;
      if (k == 11) cpu_req = 1'b0;
    end
    chk("lat3 ext_rdata", 32'(s_ext_rdata), 32'h3C3C);
    chk("lat3 cpu_rdata", 32'(s_cpu_rdata), 32'h4D4D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: the CPU (instruction fetch, stack loads and stores) and an external requester (program loader or debug port).
- Sits between the CPU core and the memory.
- Sequences each access through a small state machine: latches the request, drives the memory for a fixed read latency, captures read data, returns a one-cycle ack.
- CPU has priority; a wait counter stops it from starving the external port.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width (must be 16; byte mode uses bits 7:0).
- RD_LAT, 1, cycles from first mem_rd cycle to mem_rdata valid (1..7).
- EXT_MAX_WAIT, 4, number of consecutive CPU grants while ext_req is pending before ext is forced (1..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_byt  in  1  byte access.
- cpu_addr  in  ADDR_W  address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes the CPU phase sequencer.
- ext_req, ext_we, ext_byt, ext_addr, ext_wdata  in  as CPU equivalents  external request.
- ext_rdata  out  DATA_W  registered read data.
- ext_ack  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_byt  out  1  memory byte mode.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; wait counter = 0.
  - All outputs 0, including cpu_rdata and ext_rdata.
  - A reset during ACCESS drops mem_wr/mem_rd immediately and discards the transaction; no ack is issued.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - Grant selection: if ext_req and (~cpu_req or waitcnt == EXT_MAX_WAIT), grant ext; else if cpu_req, grant cpu.
  - On grant, latch owner, we, byt, addr and wdata, then go to ACCESS.
  - mem_* outputs are 0 in IDLE.
- Wait counter:
  - Increments when cpu is granted while ext_req = 1.
  - Clears when ext is granted, or when ext_req = 0 in IDLE.
  - Saturates at EXT_MAX_WAIT.
- ACCESS, write:
  - mem_wr = 1 for exactly one cycle, with latched addr, wdata and byt.
  - Owner's ack = 1 in that same cycle; next state IDLE.
  - Write latency: request sampled at cycle T, ack at T+1.
- ACCESS, read:
  - mem_rd = 1; down-counter loaded with RD_LAT.
  - Stay in ACCESS for RD_LAT cycles, then go to CAPTURE. mem_rd stays 1 through CAPTURE.
- CAPTURE:
  - Load the owner's rdata register from mem_rdata. If byt, load {8'h00, mem_rdata[7:0]} (zero-extend).
  - Next state DONE.
- DONE:
  - Owner's ack = 1; rdata already valid; mem_rd = 0.
  - Next state IDLE.
  - Read latency: request at T, ack at T+RD_LAT+2.
- Data hold:
  - mem_addr, mem_wdata and mem_byt are stable from ACCESS through CAPTURE.
  - rdata registers hold their value until the next read by the same owner.
  - The non-owner's rdata never changes.
- Ack cycle rules:
  - Requests are ignored in the ack cycle.
  - The requester deasserts req, or presents a new transaction, in the cycle after ack.
  - A req still held in the next IDLE cycle is treated as a new transaction.
- Simultaneous requests: cpu wins unless the wait counter is saturated. At most one ack is high per cycle; cpu_ack and ext_ack are never both 1.
- Request changes: changes to a requester's inputs after grant have no effect (inputs are latched).

Test Plan:
- Reset, then cpu read addr 16'h0100 with mem_rdata = 16'hBEEF, RD_LAT = 1 -> mem_rd high cycles T+1..T+2, cpu_ack at T+3, cpu_rdata = 16'hBEEF, cpu_stall high T..T+2.
- cpu byte read 16'h0101 with mem_rdata = 16'h12AB -> cpu_rdata = 16'h00AB, mem_byt = 1 throughout.
- ext write 16'h0200 <- 16'h5A5A while cpu idle -> mem_wr for one cycle at T+1 with matching addr/wdata, ext_ack at T+1, cpu_rdata unchanged.
- cpu_req and ext_req both held continuously, EXT_MAX_WAIT = 4 -> grant order cpu, cpu, cpu, cpu, ext, then repeats; no ack overlap.
- Assert rst low mid-read (in CAPTURE) -> mem_rd, acks and rdata go to 0 immediately; after release, state is IDLE and a new cpu read completes normally.
- RD_LAT = 3, ext read -> mem_rd high for 4 cycles, ext_ack at T+5, cpu_stall stays high while a concurrent cpu_req waits.
